// File: rtl/store_execution.sv
// rtl/store_execution.sv - STORE executor: fetches vector tiles from the buffer controller and
// streams them byte by byte to DRAM starting at a latched base address.
module store_execution #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256,
  parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [4:0]                                  opcode,
  input  logic [4:0]                                  src_buffer_id,
  input  logic [9:0]                                  length,
  input  logic [ADDR_WIDTH-1:0]                       addr,
  output logic                                        done,
  output logic                                        vec_read_enable,
  output logic [4:0]                                  vec_read_buffer_id,
  input  logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] vec_read_tile,
  input  logic                                        vec_read_valid,
  output logic                                        mem_wr_valid,
  input  logic                                        mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]                       mem_wr_addr,
  output logic [DATA_WIDTH-1:0]                       mem_wr_data
);

  localparam int TIDX_W = $clog2(TILE_ELEMS);
  localparam logic [4:0] OP_STORE = 5'h03;
  localparam logic [TIDX_W-1:0] LAST_TIDX = TIDX_W'(TILE_ELEMS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ_TILE,
    WAIT_TILE,
    WRITE,
    COMPLETE
  } state_t;

  state_t state, state_n;

  logic [4:0]                            buf_id_q;
  logic [9:0]                            length_q;
  logic [ADDR_WIDTH-1:0]                 addr_q;
  logic [9:0]                            elem_idx;
  logic [TIDX_W-1:0]                     tile_idx;
  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_q;
  logic                                  last_elem;

  assign last_elem          = (elem_idx + 10'd1) == length_q;
  assign vec_read_buffer_id = buf_id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers; the decision to run is made from the live inputs in IDLE,
  // everything used afterwards comes from the latched copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done     <= 1'b0;
      buf_id_q <= '0;
      length_q <= '0;
      addr_q   <= '0;
      elem_idx <= '0;
      tile_idx <= '0;
      tile_q   <= '0;
    end else begin
      done <= (state == COMPLETE);
      case (state)
        IDLE: begin
          if (start) begin
            buf_id_q <= src_buffer_id;
            length_q <= length;
            addr_q   <= addr;
            elem_idx <= '0;
            tile_idx <= '0;
          end
        end
        WAIT_TILE: begin
          if (vec_read_valid) begin
            tile_q <= vec_read_tile;
          end
        end
        WRITE: begin
          if (mem_wr_ready) begin
            elem_idx <= elem_idx + 10'd1;
            tile_idx <= tile_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n         = state;
    vec_read_enable = 1'b0;
    mem_wr_valid    = 1'b0;
    mem_wr_addr     = '0;
    mem_wr_data     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = (opcode == OP_STORE && length != 10'd0) ? REQ_TILE : COMPLETE;
        end
      end
      REQ_TILE: begin
        vec_read_enable = 1'b1;
        state_n         = WAIT_TILE;
      end
      WAIT_TILE: begin
        if (vec_read_valid) begin
          state_n = WRITE;
        end
      end
      WRITE: begin
        mem_wr_valid = 1'b1;
        mem_wr_addr  = addr_q + ADDR_WIDTH'(elem_idx);
        mem_wr_data  = tile_q[tile_idx];
        if (mem_wr_ready) begin
          if (last_elem) begin
            state_n = COMPLETE;
          end else if (tile_idx == LAST_TIDX) begin
            state_n = REQ_TILE;
          end
        end
      end
      COMPLETE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
